// File: rtl/result_commit_ctrl.sv
// result_commit_ctrl: drops duplicate top-3 classifier results and queues committed top-1 indices
// in a show-ahead character FIFO, forgetting the history after an idle gap.
module result_commit_ctrl #(
  parameter int IDX_W      = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int MATCH_TH   = 2,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [2:0][IDX_W-1:0]           i_tops,
  input  logic                            i_flush,
  output logic                            o_char_valid,
  input  logic                            i_char_ready,
  output logic [IDX_W-1:0]                o_char,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
  output logic [7:0]                      o_dup_cnt,
  output logic                            o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int NV = 1 << IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT} state_t;

  state_t                state, state_nx;
  logic [2:0][IDX_W-1:0] cur, prev;
  logic                  prev_valid;
  logic [GW-1:0]         gap;
  logic [NV-1:0]         pv, cv;
  logic [1:0]            overlap;
  logic                  accept, dup, room, push, pop;
  logic [IDX_W-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [7:0]            dup_cnt;

  // Presence vectors make repeated indices inside one result count once.
  always_comb begin
    pv = '0;
    cv = '0;
    overlap = '0;
    for (int k = 0; k < 3; k++) begin
      pv[prev[k]] = 1'b1;
      cv[cur[k]] = 1'b1;
    end
    for (int i = 0; i < NV; i++) overlap = overlap + {1'b0, pv[i] & cv[i]};
  end

  assign accept       = state == S_IDLE && i_valid && !i_flush;
  assign dup          = state == S_CHECK && prev_valid && overlap >= 2'(MATCH_TH);
  assign room         = count < CW'(FIFO_DEPTH);
  assign push         = state == S_COMMIT && room && !i_flush;
  assign pop          = o_char_valid && i_char_ready && !i_flush;
  assign o_ready      = state == S_IDLE;
  assign o_busy       = state != S_IDLE;
  assign o_char_valid = count != '0;
  assign o_char       = o_char_valid ? mem[rptr] : '0;
  assign o_fifo_count = count;
  assign o_dup_cnt    = dup_cnt;

  always_comb begin
    state_nx = state;
    if (i_flush) state_nx = S_IDLE;
    else begin
      unique case (state)
        S_IDLE:   state_nx = i_valid ? S_CHECK : S_IDLE;
        S_CHECK:  state_nx = dup ? S_IDLE : S_COMMIT;
        S_COMMIT: state_nx = room ? S_IDLE : S_COMMIT;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= S_IDLE;
    else state <= state_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      gap        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dup_cnt    <= '0;
    end else if (i_flush) begin
      prev_valid <= 1'b0;
      gap        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      if (accept) begin
        cur <= i_tops;
        gap <= '0;
      end else if (state == S_IDLE && prev_valid) begin
        if (gap == GW'(GAP_CYCLES - 1)) begin
          gap        <= '0;
          prev_valid <= 1'b0;
        end else gap <= gap + 1'b1;
      end
      if (dup || push) begin
        prev       <= cur;
        prev_valid <= 1'b1;
      end
      if (dup && dup_cnt != 8'hFF) dup_cnt <= dup_cnt + 8'd1;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk)
    if (push) mem[wptr] <= cur[0];
endmodule
